// File: rtl/led_pkg.sv
// Shared definitions for the multiplexed 7-segment display driver:
// slot FSM states, the active-low hex glyph table and the blank pattern.
package led_pkg;

  // Each digit slot is an all-off guard interval followed by an ON interval
  typedef enum logic {
    GUARD = 1'b0,
    ON    = 1'b1
  } slot_state_e;

  // Segments a..g on bits 6..0, active-low; all high = nothing lit
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Hex glyphs 0..F, active-low, segment a on bit 6
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06,
    7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h08, 7'h60,
    7'h31, 7'h42, 7'h30, 7'h38
  };

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational hex nibble to active-low 7-segment glyph.
module seg7_hex_decoder
  import led_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  // Table lookup; every nibble value has an entry
  always_comb begin
    glyph = HEX_SEG[nibble];
  end

endmodule

// File: rtl/multi_digit_led_driver.sv
// N-digit multiplexed 7-segment driver with guard blanking, brightness
// duty cycling and a frame-synchronous double-buffered load.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zero
// digits (digit 0 always shown); without it no blanking logic is built.
module multi_digit_led_driver
  import led_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int GUARD_CYCLES = 2,
  parameter int SUB_CYCLES   = 4,
  parameter int BRIGHT_W     = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_start
);

  localparam int ON_CYCLES = SUB_CYCLES * (2 ** BRIGHT_W);
  localparam int CNT_MAX   = (ON_CYCLES > GUARD_CYCLES) ? ON_CYCLES : GUARD_CYCLES;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);
  localparam int IDX_W     = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0] LAST_DIGIT = IDX_W'(NUM_DIGITS - 1);

  slot_state_e               state;
  logic [CNT_W-1:0]          cnt;
  logic [IDX_W-1:0]          idx;
  logic [BRIGHT_W-1:0]       bright_q;

  logic [4*NUM_DIGITS-1:0]   staging_val;
  logic [NUM_DIGITS-1:0]     staging_dp;
  logic                      pending;
  logic [4*NUM_DIGITS-1:0]   shadow_val;
  logic [NUM_DIGITS-1:0]     shadow_dp;

  logic                      guard_done;
  logic                      on_done;
  logic                      boundary;
  logic                      wrap;
  logic                      lit;
  logic [CNT_W-1:0]          lit_len;
  logic [3:0]                cur_nibble;
  logic [6:0]                cur_glyph;
  logic [NUM_DIGITS-1:0]     blank;

  // Slot timing decodes. The boundary is the first guard cycle of the top
  // digit; frame_start is high during exactly that cycle.
  always_comb begin
    guard_done = (state == GUARD) && (cnt == CNT_W'(GUARD_CYCLES - 1));
    on_done    = (state == ON) && (cnt == CNT_W'(ON_CYCLES - 1));
    boundary   = (state == GUARD) && (cnt == '0) && (idx == LAST_DIGIT);
    wrap       = on_done && (idx == '0);
    lit_len    = CNT_W'((int'(bright_q) + 1) * SUB_CYCLES);
    cur_nibble = shadow_val[{idx, 2'b00} +: 4];
    lit        = (state == ON) && (cnt < lit_len) && !blank[idx];
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic zero_run;

  // Blank the unbroken run of zero, no-dp digits from the top; digit 0 never
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    zero_run = 1'b1;
    blank    = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run = zero_run & (shadow_val[4*i +: 4] == 4'h0) & ~shadow_dp[i];
      blank[i] = zero_run;
    end
  end
`else
  assign blank = '0;
`endif

  seg7_hex_decoder u_decoder (
    .nibble (cur_nibble),
    .glyph  (cur_glyph)
  );

  // Slot FSM: guard then ON per digit, scanning from the top digit down
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state    <= GUARD;
      cnt      <= '0;
      idx      <= LAST_DIGIT;
      bright_q <= '0;
    end else begin
      case (state)
        GUARD: begin
          if (guard_done) begin
            state    <= ON;
            cnt      <= '0;
            bright_q <= brightness;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ON: begin
          if (on_done) begin
            state <= GUARD;
            cnt   <= '0;
            idx   <= (idx == '0) ? LAST_DIGIT : idx - 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // Double buffer: loads land in staging, move to shadow only at a boundary;
  // a load on the boundary cycle itself goes straight to shadow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      staging_val <= '0;
      staging_dp  <= '0;
      pending     <= 1'b0;
      shadow_val  <= '0;
      shadow_dp   <= '0;
    end else if (boundary) begin
      pending <= 1'b0;
      if (load) begin
        shadow_val <= value;
        shadow_dp  <= dp_in;
      end else if (pending) begin
        shadow_val <= staging_val;
        shadow_dp  <= staging_dp;
      end
    end else if (load) begin
      staging_val <= value;
      staging_dp  <= dp_in;
      pending     <= 1'b1;
    end
  end

  // Registered pin drivers, one cycle behind the slot FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an          <= '1;
      seg         <= SEG_OFF;
      dp          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      an          <= lit ? ~(NUM_DIGITS'(1) << idx) : '1;
      seg         <= (state == ON) ? cur_glyph : SEG_OFF;
      dp          <= (state == ON) ? ~shadow_dp[idx] : 1'b1;
      frame_start <= wrap;
    end
  end

endmodule

// File: doc/multi_digit_led_driver.md
# multi_digit_led_driver

Parametrised N-digit multiplexed 7-segment driver, the generalised successor to the board's fixed four-digit driver. It time-multiplexes a configurable number of hex digits onto shared segment lines, with:
- per-digit decimal points and a guard (ghost-blanking) interval between digits;
- brightness control by in-slot duty cycling;
- a load handshake that double-buffers the displayed value so it only changes on frame boundaries (no tearing).

It sits after the reset synchroniser/debouncer and the clock divider, directly driving the board pins.

## Interface
- NUM_DIGITS, 4, digit count; legal 2..8
- GUARD_CYCLES, 2, all-anodes-off cycles at start of each digit slot; legal >= 1
- SUB_CYCLES, 4, cycles per brightness sub-slice; legal >= 1
- BRIGHT_W, 2, brightness width; ON phase = SUB_CYCLES * 2^BRIGHT_W cycles
- clk  input  1  single clock; all logic on rising edge
- reset  input  1  asynchronous, active-high
- value  input  4*NUM_DIGITS  hex nibbles; nibble i = digit i, digit 0 least significant
- dp_in  input  NUM_DIGITS  decimal point request per digit, 1 = lit
- load  input  1  one-cycle strobe, captures value/dp_in into staging
- brightness  input  BRIGHT_W  0 = dimmest (1 sub-slice), max = full ON phase
- an  output  NUM_DIGITS  anodes, active-low
- seg  output  7  segments a..g at bits 6..0, active-low
- dp  output  1  decimal point, active-low
- frame_start  output  1  one-cycle pulse at each frame boundary

## Operation
- Reset values:
  - an all 1, seg 7'h7F, dp 1, frame_start 0.
  - staging, shadow and pending cleared to 0.
  - Digit index = NUM_DIGITS-1; state GUARD; cycle counter 0.
- Two-state FSM per digit slot:
  - GUARD, GUARD_CYCLES long: all anodes high, seg/dp high.
  - ON, SUB_CYCLES*2^BRIGHT_W long.
  - The ON→GUARD transition advances the digit index downward (NUM_DIGITS-1 … 0, then wraps to NUM_DIGITS-1).
- Brightness:
  - Sampled on GUARD→ON entry and held for that slot.
  - Anode of the current digit is low during the first (brightness+1) sub-slices of ON, high for the rest. seg/dp are driven for the whole ON phase.
- Decode:
  - Shadow nibble of current digit → hex glyph 0–F (standard 7-seg: 0=7'h01, 8=7'h00, F=7'h38 active-low).
  - dp = ~shadow_dp[current digit].
- Load handshake:
  - load=1 copies value/dp_in into staging and sets pending. Last load before a boundary wins.
  - Frame boundary = the cycle entering GUARD of digit NUM_DIGITS-1. At the boundary, if pending: shadow ← staging, pending cleared.
  - load asserted on the boundary cycle itself: its data goes straight to shadow (bypass), and pending stays clear.
- frame_start pulses on every boundary regardless of pending.
- Reset mid-frame: immediate return to reset values; the display resumes from GUARD of digit NUM_DIGITS-1. No frame_start pulse on the first post-reset boundary.

## Timing
- Slot = GUARD_CYCLES + SUB_CYCLES*2^BRIGHT_W cycles; frame = NUM_DIGITS × slot.
- an/seg/dp/frame_start are registered and lag the internal FSM state by exactly one cycle.
- Defaults: slot 18, frame 72. After reset release, an[3] is low in cycles 3..18 at max brightness, counting the first edge as cycle 1.
- Anodes of two digits are never low in the same cycle. Every digit change has at least GUARD_CYCLES all-high cycles between.
- load→visible latency: up to one frame plus one cycle.

## Configuration
- LEADING_ZERO_BLANK_EN defined:
  - Scanning from digit NUM_DIGITS-1 downward, each digit whose shadow nibble is 0 and whose shadow dp is 0 is blanked, until the first non-qualifying digit.
  - Blanked means anode held high during ON.
  - Digit 0 is never blanked.
  - The mask is computed from shadow only, so it changes only at frame boundaries.
- Not defined: all digits are always displayed; no blanking logic is synthesised.

## Structure
- Shared package (led_pkg) holds:
  - FSM state enum (GUARD, ON);
  - 16-entry hex-to-segment constant table;
  - SEG_OFF = 7'h7F.
- One natural sub-module: seg7_hex_decoder (4-bit nibble → 7-bit active-low glyph, combinational), reused by the top.
- Top holds the counters, FSM, staging/shadow registers and output registers.

## Test plan
- Reset release, value=16'h1234, load pulse, defaults, brightness=3 → from the second frame the scan is an=4'b0111 seg=1, 4'b1011 seg=2, 4'b1101 seg=3, 4'b1110 seg=4; each digit is low 16 cycles with 2 all-high cycles between.
- brightness=0, same value → each anode low exactly 4 cycles per 18-cycle slot; seg held 16 cycles.
- load value=16'hABCD mid-frame → display stays 1234 until the next frame_start, then shows ABCD. A second load (16'h0F0F) in the same frame → only 0F0F appears.
- load asserted exactly on the frame_start cycle with 16'h5555 → the following frame shows 5555 with no one-frame delay.
- LEADING_ZERO_BLANK_EN defined, value=16'h0007, dp_in=0 → an[3:1] never low, digit 0 shows 7. With dp_in=4'b0100 → digit 2 shows "0." and digit 3 stays blank.
- reset asserted in the ON phase of digit 1 → an=4'hF, seg=7'h7F asynchronously. After release, the scan restarts at digit 3 showing 0000.
